// File: rtl/matmul_sequencer.sv
// Run controller for one systolic matmul pass: clear, row fetch, wait for the
// decoder's compute_start, time the compute window, then report done/error.
module matmul_sequencer #(
  parameter int REG_WIDTH      = 16,
  parameter int MATRIX_SIZE    = 4,
  parameter int ADDR_WIDTH     = 8,
  parameter int RD_LAT         = 1,
  parameter int COMPUTE_CYCLES = 10,
  parameter int TIMEOUT        = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  output logic                  bram_en,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic                  dec_enable,
  output logic                  dec_reset,
  output logic                  acc_clear,
  input  logic                  compute_start,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  // state    | meaning
  // IDLE     | waiting for start, decoder held in reset
  // CLEAR    | one-cycle accumulator clear
  // LOAD     | MATRIX_SIZE consecutive row reads
  // WAIT_CS  | waiting for decoder compute_start, bounded by TIMEOUT
  // COMPUTE  | array compute/flush window of COMPUTE_CYCLES
  // DONE     | one-cycle done pulse
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CLEAR   = 3'd1;
  localparam logic [2:0] S_LOAD    = 3'd2;
  localparam logic [2:0] S_WAIT_CS = 3'd3;
  localparam logic [2:0] S_COMPUTE = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  localparam int WORD_WIDTH = MATRIX_SIZE * REG_WIDTH;
  localparam int MAX_AB  = (MATRIX_SIZE > TIMEOUT) ? MATRIX_SIZE : TIMEOUT;
  localparam int CNT_MAX = (MAX_AB > COMPUTE_CYCLES) ? MAX_AB : COMPUTE_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int CNT_W_CHK = (WORD_WIDTH > 0) ? CNT_W : 1;

  localparam logic [CNT_W_CHK-1:0] LOAD_TC    = CNT_W_CHK'(MATRIX_SIZE - 1);
  localparam logic [CNT_W_CHK-1:0] TIMEOUT_TC = CNT_W_CHK'(TIMEOUT - 1);
  localparam logic [CNT_W_CHK-1:0] COMPUTE_TC = CNT_W_CHK'(COMPUTE_CYCLES - 1);

  logic [2:0]            state_q, state_d;
  logic [CNT_W_CHK-1:0]  cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  err_q, err_d;
  logic [RD_LAT-1:0]     pipe_q, pipe_d;
  logic                  bram_en_q, bram_en_d;
  logic                  dec_reset_q, dec_reset_d;
  logic                  acc_clear_q, acc_clear_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  // Down-counter reloaded on every phase entry; terminal count is zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    base_d  = base_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CLEAR;
          base_d  = base_addr;
          err_d   = 1'b0;
        end
      end
      S_CLEAR: begin
        state_d = S_LOAD;
        cnt_d   = LOAD_TC;
      end
      S_LOAD: begin
        if (cnt_q == '0) begin
          state_d = S_WAIT_CS;
          cnt_d   = TIMEOUT_TC;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_WAIT_CS: begin
        if (compute_start) begin
          state_d = S_COMPUTE;
          cnt_d   = COMPUTE_TC;
        end else if (cnt_q == '0) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_COMPUTE: begin
        if (cnt_q == '0) state_d = S_DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they align with it.
  always_comb begin
    addr_d      = addr_q;
    if (state_d == S_LOAD) addr_d = (state_q == S_LOAD) ? addr_q + 1'b1 : base_q;
    bram_en_d   = (state_d == S_LOAD);
    acc_clear_d = (state_d == S_CLEAR);
    dec_reset_d = (state_d == S_IDLE) || (state_d == S_CLEAR);
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    pipe_d      = RD_LAT'({pipe_q, bram_en_q});
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      base_q      <= '0;
      addr_q      <= '0;
      err_q       <= 1'b0;
      pipe_q      <= '0;
      bram_en_q   <= 1'b0;
      dec_reset_q <= 1'b1;
      acc_clear_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      base_q      <= base_d;
      addr_q      <= addr_d;
      err_q       <= err_d;
      pipe_q      <= pipe_d;
      bram_en_q   <= bram_en_d;
      dec_reset_q <= dec_reset_d;
      acc_clear_q <= acc_clear_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bram_en    = bram_en_q;
  assign bram_addr  = addr_q;
  assign dec_enable = pipe_q[RD_LAT-1];
  assign dec_reset  = dec_reset_q;
  assign acc_clear  = acc_clear_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = err_q;

endmodule

// File: tb/tb_matmul_sequencer.sv
// Scoreboard bench for matmul_sequencer: stimulus pushes expected pulse events
// (cycle + payload) per run, a negedge monitor pops them as the DUT emits them.
module tb_matmul_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] base_addr;
  logic       compute_start;
  logic       bram_en, dec_enable, dec_reset, acc_clear, busy, done, error;
  logic [7:0] bram_addr;

  matmul_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .bram_en(bram_en), .bram_addr(bram_addr), .dec_enable(dec_enable),
    .dec_reset(dec_reset), .acc_clear(acc_clear), .compute_start(compute_start),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; int val; } ev_t;
  ev_t q_clr[$], q_rd[$], q_dec[$], q_done[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_ev(input string nm, input ev_t e, input int val);
    chk({nm, " cycle"}, cyc, e.cyc);
    chk({nm, " value"}, val, e.val);
  endtask

  // Monitor: every asserted pulse must match the oldest expected event.
  always @(negedge clk) begin
    ev_t e;
    if (acc_clear === 1'b1) begin
      if (q_clr.size() == 0) chk("unexpected acc_clear", 1, 0);
      else begin e = q_clr.pop_front(); chk_ev("acc_clear", e, 0); end
    end
    if (bram_en === 1'b1) begin
      if (q_rd.size() == 0) chk("unexpected bram_en", 1, 0);
      else begin e = q_rd.pop_front(); chk_ev("bram_addr", e, int'(bram_addr)); end
    end
    if (dec_enable === 1'b1) begin
      if (q_dec.size() == 0) chk("unexpected dec_enable", 1, 0);
      else begin e = q_dec.pop_front(); chk_ev("dec_enable", e, 0); end
    end
    if (done === 1'b1) begin
      if (q_done.size() == 0) chk("unexpected done", 1, 0);
      else begin e = q_done.pop_front(); chk_ev("done/error", e, int'(error)); end
    end
  end

  // One pass starting in the current cycle. d<0: no compute_start (timeout).
  // abort_r>=0: reset pulled low at that relative cycle.
  task automatic run_pass(input logic [7:0] base, input int d, input bit noise,
                          input int abort_r);
    int s, done_r, last;
    s = cyc;
    done_r = (d < 0) ? 6 + 32 : 7 + d + 10;
    q_clr.push_back('{s + 1, 0});
    for (int k = 0; k < 4; k++) begin
      q_rd.push_back('{s + 2 + k, (int'(base) + k) % 256});
      q_dec.push_back('{s + 3 + k, 0});
    end
    if (abort_r < 0) q_done.push_back('{s + done_r, (d < 0) ? 1 : 0});
    last = (abort_r >= 0) ? abort_r : done_r;
    for (int r = 0; r <= last; r++) begin
      start = (r == 0) || (noise && (r == 3 || r == 12) && r != abort_r);
      base_addr = (r == 0) ? base : 8'($urandom);
      compute_start = (d >= 0 && r == 6 + d) ||
                      (noise && (r == 3 || (d >= 0 && r == 9 + d)));
      if (r == 1) begin
        chk("error cleared by start", int'(error), 0);
        chk("busy in CLEAR", int'(busy), 1);
        chk("dec_reset in CLEAR", int'(dec_reset), 1);
      end
      if (r == 2) chk("dec_reset in LOAD", int'(dec_reset), 0);
      if (r == abort_r) begin
        start = 1'b0;
        reset = 1'b0;
        #1;
        chk("abort busy", int'(busy), 0);
        chk("abort dec_reset", int'(dec_reset), 1);
        chk("abort done", int'(done), 0);
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    compute_start = 1'b0;
    if (abort_r >= 0) begin
      reset = 1'b1;
      @(posedge clk); #1;
      chk("error after abort", int'(error), 0);
    end else begin
      chk("busy after done", int'(busy), 0);
      chk("sticky error", int'(error), (d < 0) ? 1 : 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    start = 1'b1;
    base_addr = 8'h55;
    compute_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset bram_en", int'(bram_en), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset dec_reset", int'(dec_reset), 1);
    chk("reset error", int'(error), 0);
    chk("reset done", int'(done), 0);
    chk("reset acc_clear", int'(acc_clear), 0);
    start = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;

    run_pass(8'h08, 3, 1'b0, -1);
    run_pass(8'hFE, 0, 1'b0, -1);
    run_pass(8'h20, -1, 1'b0, -1);
    run_pass(8'h21, 5, 1'b1, -1);
    run_pass(8'h40, 2, 1'b1, 12);
    run_pass(8'h41, 1, 1'b0, -1);
    for (int i = 0; i < 12; i++) begin
      int d;
      d = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 30));
      run_pass(8'($urandom), d, 1'($urandom), -1);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
      end
    end
    repeat (3) @(posedge clk);
    #1;
    chk("leftover clear events", q_clr.size(), 0);
    chk("leftover read events", q_rd.size(), 0);
    chk("leftover dec events", q_dec.size(), 0);
    chk("leftover done events", q_done.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
